// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_CYCLES_PER_BIT = 868;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP,
    UART_WAIT_IDLE
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with combinational head read; a pop frees a slot for a same-cycle push.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [7:0]                  wdata,
  output logic [7:0]                  rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Depth is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_sink.sv
// UART 8N1 receiver feeding a byte FIFO with a valid/ready output.
// Define UART_RX_PARITY_EN to expect one even-parity bit before the stop bit.
module uart_rx_sink
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = UART_CYCLES_PER_BIT,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        parity_err
);

  localparam int          CW   = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CYCLES_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic          rx_m, rx_s;
  uart_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick, push, fifo_full, fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (cnt == '0);
  assign busy = (state != UART_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign push = (state == UART_STOP) && tick && rx_s && !par_bad;
`else
  assign push = (state == UART_STOP) && tick && rx_s;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UART_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      // Full implies out_valid, so out_ready alone decides whether a slot frees up.
      overrun   <= push && fifo_full && !out_ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        UART_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF;
            state <= UART_START;
          end
        end
        UART_START: begin
          if (tick) begin
            if (!rx_s) begin
              cnt     <= FULL;
              bit_idx <= '0;
              state   <= UART_DATA;
            end else begin
              state <= UART_IDLE;
            end
          end else cnt <= cnt - 1'b1;
        end
        UART_DATA: begin
          if (tick) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == LAST_BIT) state <= UART_PARITY;
`else
            if (bit_idx == LAST_BIT) state <= UART_STOP;
`endif
          end else cnt <= cnt - 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        UART_PARITY: begin
          if (tick) begin
            par_bad <= ^{shreg, rx_s};
            cnt     <= FULL;
            state   <= UART_STOP;
          end else cnt <= cnt - 1'b1;
        end
`endif
        UART_STOP: begin
          if (tick) begin
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              state <= UART_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= UART_WAIT_IDLE;
            end
          end else cnt <= cnt - 1'b1;
        end
        // A held-low line (break) must not be decoded as repeated 0x00 bytes.
        UART_WAIT_IDLE: begin
          if (rx_s) state <= UART_IDLE;
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_valid && out_ready),
    .wdata (shreg),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed bench for uart_rx_sink with CYCLES_PER_BIT=8, FIFO_DEPTH=4.
module tb_uart_rx_sink;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Edges after the edge preceding the start bit until the push edge, minus one.
  localparam int LAT = 2 + 1 + CPB/2 + 8*CPB + PBITS*CPB + CPB - 1;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, busy, frame_err, overrun, parity_err;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_tests = 0, n_fail = 0;
  int n_ferr, n_ovr, n_perr;
  bit busy_seen;
  logic [7:0] popped[$];

  uart_rx_sink #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (parity_err) n_perr++;
      if (busy)       busy_seen = 1'b1;
      if (out_valid && out_ready) popped.push_back(out_data);
    end
  end

  task automatic clear_mon();
    n_ferr = 0; n_ovr = 0; n_perr = 0; busy_seen = 1'b0;
    popped.delete();
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rx = 1'b0; repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; repeat (CPB) @(posedge clk); #1;
    end
    if (PBITS != 0) begin
      rx = (^d) ^ par_flip; repeat (CPB) @(posedge clk); #1;
    end
    rx = stop_bit; repeat (CPB) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_tests++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags got %b want 000", {frame_err, overrun, parity_err}); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_single();
    clear_mon(); out_ready = 1'b1;
    fork
      send(8'h55, 1'b1, 1'b0);
      begin
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
        n_tests++; if (out_data !== 8'h55) begin n_fail++; $display("FAIL single_data got %h want 55", out_data); end
      end
    join
    repeat (4) @(posedge clk); #1;
    n_tests++; if (popped.size() != 1) begin n_fail++; $display("FAIL single_beats got %0d want 1", popped.size()); end
    n_tests++; if (n_ferr + n_ovr + n_perr != 0) begin n_fail++;
      $display("FAIL single_flags got %0d/%0d/%0d want 0/0/0", n_ferr, n_ovr, n_perr); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0; repeat (2) @(posedge clk); #1;
    rx = 1'b1; repeat (12) @(posedge clk); #1;
    n_tests++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise got %b want 1", busy_seen); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall got %b want 0", busy); end
    n_tests++; if (fifo_count !== '0 || popped.size() != 0) begin n_fail++;
      $display("FAIL glitch_push got count %0d beats %0d want 0 0", fifo_count, popped.size()); end
    n_tests++; if (n_ferr + n_ovr + n_perr != 0) begin n_fail++;
      $display("FAIL glitch_flags got %0d/%0d/%0d want 0/0/0", n_ferr, n_ovr, n_perr); end
  endtask

  task automatic test_frame_err();
    clear_mon(); out_ready = 1'b1;
    send(8'hA3, 1'b0, 1'b0);
    repeat (16) @(posedge clk); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_hold got %b want 1", busy); end
    n_tests++; if (n_ferr != 1) begin n_fail++; $display("FAIL ferr_pulses got %0d want 1", n_ferr); end
    n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL ferr_count got %0d want 0", fifo_count); end
    rx = 1'b1; repeat (4) @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release got %b want 0", busy); end
    n_tests++; if (popped.size() != 0 || n_ferr != 1) begin n_fail++;
      $display("FAIL ferr_after got beats %0d pulses %0d want 0 1", popped.size(), n_ferr); end
  endtask

  task automatic test_overrun();
    clear_mon(); out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
    repeat (4) @(posedge clk); #1;
    n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovr_count got %0d want 4", fifo_count); end
    n_tests++; if (n_ovr != 1) begin n_fail++; $display("FAIL ovr_pulses got %0d want 1", n_ovr); end
    out_ready = 1'b1; repeat (8) @(posedge clk); #1; out_ready = 1'b0;
    n_tests++; if (popped.size() != 4) begin n_fail++; $display("FAIL ovr_beats got %0d want 4", popped.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (popped.size() > i && popped[i] !== 8'(i + 1)) begin n_fail++;
        $display("FAIL ovr_order[%0d] got %h want %h", i, popped[i], 8'(i + 1)); end
    end
    n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL ovr_drain got %0d want 0", fifo_count); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp [5];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; exp[4] = 8'h99;
    clear_mon(); out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(exp[i], 1'b1, 1'b0);
    n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fullpop_fill got %0d want 4", fifo_count); end
    fork
      send(8'h99, 1'b1, 1'b0);
      begin
        repeat (LAT) @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
      end
    join
    repeat (2) @(posedge clk); #1;
    n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count got %0d want 4", fifo_count); end
    n_tests++; if (n_ovr != 0) begin n_fail++; $display("FAIL fullpop_overrun got %0d want 0", n_ovr); end
    out_ready = 1'b1; repeat (8) @(posedge clk); #1; out_ready = 1'b0;
    n_tests++; if (popped.size() != 5) begin n_fail++; $display("FAIL fullpop_beats got %0d want 5", popped.size()); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (popped.size() > i && popped[i] !== exp[i]) begin n_fail++;
        $display("FAIL fullpop_order[%0d] got %h want %h", i, popped[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h7E;
    clear_mon(); out_ready = 1'b1;
    rx = 1'b0; repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      rx = d[i]; repeat (CPB) @(posedge clk); #1;
    end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    rst = 1'b1; rx = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if ({out_valid, busy, frame_err, overrun, parity_err} !== 5'b0 || fifo_count !== '0) begin n_fail++;
      $display("FAIL rstmid_outputs got v%b b%b f%b o%b p%b c%0d want all 0",
               out_valid, busy, frame_err, overrun, parity_err, fifo_count); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    send(8'h3C, 1'b1, 1'b0);
    repeat (6) @(posedge clk); #1;
    n_tests++; if (popped.size() != 1 || popped[0] !== 8'h3C) begin n_fail++;
      $display("FAIL rstmid_rx got %0d beats first %h want 1 beat 3c", popped.size(), popped[0]); end
    n_tests++; if (n_ferr + n_ovr + n_perr != 0) begin n_fail++;
      $display("FAIL rstmid_flags got %0d/%0d/%0d want 0/0/0", n_ferr, n_ovr, n_perr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon(); out_ready = 1'b1;
    send(8'h3C, 1'b1, 1'b1);
    repeat (4) @(posedge clk); #1;
    n_tests++; if (n_perr != 1) begin n_fail++; $display("FAIL parity_pulses got %0d want 1", n_perr); end
    n_tests++; if (popped.size() != 0 || fifo_count !== '0) begin n_fail++;
      $display("FAIL parity_push got beats %0d count %0d want 0 0", popped.size(), fifo_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
